// File: rtl/chip8_display_engine.sv
// rtl/chip8_display_engine.sv - CHIP-8 64x32 framebuffer with sprite-row XOR draw, clear and scan-out read
//
// Purpose:
//   Services draw requests from chip8_cpu by XORing one 8-pixel sprite row
//   into a 64x32 monochrome framebuffer (wrapping both horizontally and
//   vertically), reports collisions, runs the 32-cycle clear sequence and
//   provides a registered pixel read port for video scan-out.
//
// Ports:
//   clk            - system clock
//   reset          - asynchronous, active-high reset
//   draw           - 1-cycle request to XOR one sprite row
//   x, y           - sprite origin column / row
//   sprite_data    - row bits, bit7 is the leftmost pixel at column x
//   draw_row_index - sprite row offset, target row = y + index (mod 32)
//   clear          - 1-cycle request to blank the framebuffer
//   scan_x, scan_y - video read address
//   pixel          - registered framebuffer[scan_y][scan_x]
//   collision      - 1-cycle pulse: the last draw turned a lit pixel off
//   busy           - high whenever the engine is not idle
//   overrun        - 1-cycle pulse: a draw or clear request was dropped

module chip8_display_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw,
  input  logic [5:0] x,
  input  logic [4:0] y,
  input  logic [7:0] sprite_data,
  input  logic [3:0] draw_row_index,
  input  logic       clear,
  input  logic [5:0] scan_x,
  input  logic [4:0] scan_y,
  output logic       pixel,
  output logic       collision,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  lat_x;
  logic [4:0]  lat_y;
  logic [7:0]  lat_data;
  logic [3:0]  lat_idx;
  logic [4:0]  row_q;
  logic [63:0] old_q;
  logic [63:0] mask_q;
  logic [4:0]  clr_row;

  // Framebuffer storage: bit c of a row is column c. Not reset; CLEAR wipes it.
  logic [63:0] fb_row [32];

  logic [4:0]   row_c;
  logic [63:0]  base_c;
  logic [127:0] dbl_c;
  logic [63:0]  mask_c;

  // Target row wraps within the 32 rows.
  assign row_c = lat_y + {1'b0, lat_idx};

  // Sprite mask: bit-reverse the data so base bit k holds the pixel for
  // column x+k, then rotate left by x. Rotation is done by shifting a doubled
  // copy and taking the upper half, which gives the horizontal wrap for free.
  always_comb begin
    base_c = '0;
    for (int k = 0; k < 8; k++) begin
      base_c[k] = lat_data[7-k];
    end
    dbl_c  = {base_c, base_c} << lat_x;
    mask_c = dbl_c[127:64];
  end

  // Single write port: WRITE applies the XORed row, CLEAR zeroes one row.
  always_ff @(posedge clk) begin
    if (state == S_WRITE) begin
      fb_row[row_q] <= old_q ^ mask_q;
    end else if (state == S_CLEAR) begin
      fb_row[clr_row] <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_CLEAR;
      clr_row   <= '0;
      collision <= 1'b0;
      overrun   <= 1'b0;
      pixel     <= 1'b0;
      busy      <= 1'b1;
      lat_x     <= '0;
      lat_y     <= '0;
      lat_data  <= '0;
      lat_idx   <= '0;
      row_q     <= '0;
      old_q     <= '0;
      mask_q    <= '0;
    end else begin
      // Scan-out read sees pre-write data for a row written this cycle.
      pixel     <= fb_row[scan_y][scan_x];
      collision <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (clear) begin
            // Clear has priority; a simultaneous draw is dropped.
            overrun <= draw;
            clr_row <= '0;
            state   <= S_CLEAR;
            busy    <= 1'b1;
          end else if (draw) begin
            lat_x    <= x;
            lat_y    <= y;
            lat_data <= sprite_data;
            lat_idx  <= draw_row_index;
            state    <= S_READ;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        S_READ: begin
          overrun <= draw | clear;
          row_q   <= row_c;
          old_q   <= fb_row[row_c];
          mask_q  <= mask_c;
          state   <= S_WRITE;
          busy    <= 1'b1;
        end

        S_WRITE: begin
          overrun   <= draw | clear;
          collision <= |(old_q & mask_q);
          state     <= S_IDLE;
          busy      <= 1'b0;
        end

        S_CLEAR: begin
          overrun <= draw | clear;
          clr_row <= clr_row + 5'd1;
          if (clr_row == 5'd31) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_display_engine.sv
// tb/tb_chip8_display_engine.sv - self-checking bench for chip8_display_engine
//
// Purpose:
//   Drives directed and random draw/clear/scan traffic and compares every
//   output each cycle against a transaction-level framebuffer model.
//
// Ports: none (top-level bench).

module tb_chip8_display_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       draw = 1'b0;
  logic [5:0] x = '0;
  logic [4:0] y = '0;
  logic [7:0] sprite_data = '0;
  logic [3:0] draw_row_index = '0;
  logic       clear = 1'b0;
  logic [5:0] scan_x = '0;
  logic [4:0] scan_y = '0;
  logic       pixel;
  logic       collision;
  logic       busy;
  logic       overrun;

  always #5 clk = ~clk;

  chip8_display_engine dut (
    .clk            (clk),
    .reset          (rst),
    .draw           (draw),
    .x              (x),
    .y              (y),
    .sprite_data    (sprite_data),
    .draw_row_index (draw_row_index),
    .clear          (clear),
    .scan_x         (scan_x),
    .scan_y         (scan_y),
    .pixel          (pixel),
    .collision      (collision),
    .busy           (busy),
    .overrun        (overrun)
  );

  int checks   = 0;
  int failures = 0;
  int coll_seen = 0;
  int ovr_seen  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Framebuffer as plain rows; an operation is a countdown of busy cycles.
  logic [63:0] mfb [32];
  bit          row_known [32];
  int          busy_left;
  bit          op_clear;
  int          d_row;
  logic [63:0] d_mask;
  bit          model_ready = 0;
  logic        e_pix, e_coll, e_busy, e_ovr;
  bit          pix_chk;

  function automatic logic [63:0] sprite_mask(input logic [5:0] cx, input logic [7:0] d);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 8; k++)
      if (d[7-k]) m[(int'(cx) + k) % 64] = 1'b1;
    return m;
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) begin
      mfb[r] = '0;
      row_known[r] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        busy_left   = 32;
        op_clear    = 1;
        e_coll      = 0;
        e_ovr       = 0;
        e_pix       = 0;
        pix_chk     = 1;
        e_busy      = 1;
        model_ready = 1;
      end else begin
        pix_chk = row_known[scan_y];
        e_pix   = mfb[scan_y][scan_x];
        e_ovr   = (draw || clear) && (busy_left != 0 || (draw && clear));
        e_coll  = 0;
        if (busy_left != 0) begin
          if (op_clear) begin
            mfb[32 - busy_left] = '0;
            row_known[32 - busy_left] = 1;
          end else if (busy_left == 1) begin
            e_coll = |(mfb[d_row] & d_mask);
            mfb[d_row] = mfb[d_row] ^ d_mask;
          end
          busy_left--;
        end else if (clear) begin
          op_clear  = 1;
          busy_left = 32;
        end else if (draw) begin
          op_clear  = 0;
          busy_left = 2;
          d_row     = (int'(y) + int'(draw_row_index)) % 32;
          d_mask    = sprite_mask(x, sprite_data);
        end
        e_busy = (busy_left != 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (model_ready) begin
      chk("busy", busy, e_busy);
      chk("collision", collision, e_coll);
      chk("overrun", overrun, e_ovr);
      if (pix_chk) chk("pixel", pixel, e_pix);
    end
    if (collision === 1'b1) coll_seen++;
    if (overrun === 1'b1) ovr_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic draw_op(input logic [5:0] dx, input logic [4:0] dy,
                         input logic [3:0] di, input logic [7:0] dd);
    x = dx; y = dy; draw_row_index = di; sprite_data = dd; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic px(input int cx, input int cy, input logic e, input string name);
    scan_x = 6'(cx);
    scan_y = 5'(cy);
    @(negedge clk);
    chk(name, pixel, e);
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic scan_all_zero(input string name);
    for (int i = 0; i < 2048; i++) begin
      scan_x = 6'(i % 64);
      scan_y = 5'(i / 64);
      @(negedge clk);
      chk(name, pixel, 1'b0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, c0, o0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: clear after reset lasts 32 cycles, framebuffer reads all zero
    chk("reset_busy", busy, 1'b1);
    chk("reset_collision", collision, 1'b0);
    wait_idle("t1_idle", n);
    chk("t1_busy_cycles", 64'(n), 64'd32);
    scan_all_zero("t1_scan");

    // 2: basic draw then identical draw erases with collision
    c0 = coll_seen;
    draw_op(6'd0, 5'd0, 4'd0, 8'hF0);
    for (int c = 0; c < 8; c++) px(c, 0, (c < 4), "t2_draw_px");
    chk("t2_no_coll", 64'(coll_seen - c0), 64'd0);
    draw_op(6'd0, 5'd0, 4'd0, 8'hF0);
    for (int c = 0; c < 8; c++) px(c, 0, 1'b0, "t2_erase_px");
    chk("t2_coll_once", 64'(coll_seen - c0), 64'd1);

    // 3: vertical and horizontal wrap
    c0 = coll_seen;
    draw_op(6'd60, 5'd31, 4'd1, 8'hFF);
    for (int c = 56; c < 64; c++) px(c, 0, (c >= 60), "t3_hi_px");
    for (int c = 0; c < 8; c++) px(c, 0, (c < 4), "t3_lo_px");
    px(60, 31, 1'b0, "t3_row31");
    chk("t3_no_coll", 64'(coll_seen - c0), 64'd0);

    // 4: back-to-back draws every 3 cycles are all accepted
    o0 = ovr_seen;
    for (int i = 0; i < 5; i++) begin
      x = 6'd10; y = 5'd5; draw_row_index = 4'(i); sprite_data = 8'h81; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("t4_no_overrun", 64'(ovr_seen - o0), 64'd0);
    for (int r = 5; r < 10; r++)
      foreach (sprite_data[b]) px(9 + b, r, (9 + b == 10) || (9 + b == 17), "t4_px");
    px(10, 10, 1'b0, "t4_row10");

    // 5a: a draw one cycle after another is dropped
    o0 = ovr_seen;
    x = 6'd20; y = 5'd12; draw_row_index = 4'd0; sprite_data = 8'hC0; draw = 1'b1;
    @(negedge clk);
    x = 6'd40; sprite_data = 8'hFF;
    @(negedge clk);
    draw = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_overrun", 64'(ovr_seen - o0), 64'd1);
    px(20, 12, 1'b1, "t5_px20");
    px(21, 12, 1'b1, "t5_px21");
    px(22, 12, 1'b0, "t5_px22");
    px(40, 12, 1'b0, "t5_px40");

    // 5b: clear and draw together, clear wins
    o0 = ovr_seen;
    x = 6'd0; y = 5'd0; draw_row_index = 4'd0; sprite_data = 8'hFF;
    clear = 1'b1; draw = 1'b1;
    @(negedge clk);
    clear = 1'b0; draw = 1'b0;
    chk("t5_clear_busy", busy, 1'b1);
    wait_idle("t5_clear_idle", n);
    chk("t5_clear_overrun", 64'(ovr_seen - o0), 64'd1);
    px(20, 12, 1'b0, "t5_cleared20");
    px(0, 0, 1'b0, "t5_cleared0");
    px(10, 5, 1'b0, "t5_cleared10");

    // 6: reset during READ of a colliding draw
    draw_op(6'd30, 5'd20, 4'd0, 8'hFF);
    px(30, 20, 1'b1, "t6_drawn");
    c0 = coll_seen;
    x = 6'd30; y = 5'd20; draw_row_index = 4'd0; sprite_data = 8'hFF; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy_in_reset", busy, 1'b1);
    rst = 1'b0;
    wait_idle("t6_idle", n);
    chk("t6_busy_cycles", 64'(n), 64'd32);
    chk("t6_no_coll", 64'(coll_seen - c0), 64'd0);
    scan_all_zero("t6_scan");

    // random traffic, checked cycle by cycle against the model
    repeat (1500) begin
      int r;
      r = $urandom_range(0, 99);
      draw = (r < 35);
      clear = (r >= 98);
      x = 6'($urandom);
      y = 5'($urandom);
      draw_row_index = 4'($urandom);
      sprite_data = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      scan_x = 6'($urandom);
      scan_y = 5'($urandom);
      @(negedge clk);
    end
    draw = 1'b0;
    clear = 1'b0;
    wait_idle("rand_idle", n);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
